// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: a valid/ready stage between two pipeline stages.
// Build option: define ELASTIC_PIPE_SKID_EN to add a skid register. With it,
// ready_o is a pure register decode and breaks the ready path. Without it, the
// stage is a single register whose ready_o looks through to ready_i.
// The control payload reads as zero whenever the stage holds no entry.
module elastic_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef ELASTIC_PIPE_SKID_EN
    localparam logic [1:0] ST_SKID  = 2'd2;
`endif

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;

    logic [1:0]        w_state_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic              w_in_fire;
    logic              w_out_fire;

`ifdef ELASTIC_PIPE_SKID_EN
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data_d;
    logic [CTRL_W-1:0] w_skid_ctrl_d;
`endif

    // Handshake decode and output drive.
    always_comb begin
        valid_o = (r_state != ST_EMPTY);
`ifdef ELASTIC_PIPE_SKID_EN
        ready_o = (r_state != ST_SKID);
`else
        ready_o = !valid_o || ready_i;
`endif
        w_in_fire  = valid_i && ready_o;
        w_out_fire = valid_o && ready_i;
        data_o     = r_main_data;
        ctrl_o     = valid_o ? r_main_ctrl : '0;
        count_o    = r_state;
    end

    // Next-state and payload steering; flush empties the stage but keeps payloads.
    always_comb begin
        w_state_d     = r_state;
        w_main_data_d = r_main_data;
        w_main_ctrl_d = r_main_ctrl;
`ifdef ELASTIC_PIPE_SKID_EN
        w_skid_data_d = r_skid_data;
        w_skid_ctrl_d = r_skid_ctrl;
`endif
        if (flush_i) begin
            w_state_d = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_d     = ST_FULL;
                        w_main_data_d = data_i;
                        w_main_ctrl_d = ctrl_i;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_d = data_i;
                        w_main_ctrl_d = ctrl_i;
`ifdef ELASTIC_PIPE_SKID_EN
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new entry behind the head.
                        w_state_d     = ST_SKID;
                        w_skid_data_d = data_i;
                        w_skid_ctrl_d = ctrl_i;
`endif
                    end else if (w_out_fire) begin
                        w_state_d = ST_EMPTY;
                    end
                end
`ifdef ELASTIC_PIPE_SKID_EN
                ST_SKID: begin
                    if (w_out_fire) begin
                        w_state_d     = ST_FULL;
                        w_main_data_d = r_skid_data;
                        w_main_ctrl_d = r_skid_ctrl;
                    end
                end
`endif
                default: w_state_d = ST_EMPTY;
            endcase
        end
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
`ifdef ELASTIC_PIPE_SKID_EN
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_main_data <= w_main_data_d;
            r_main_ctrl <= w_main_ctrl_d;
`ifdef ELASTIC_PIPE_SKID_EN
            r_skid_data <= w_skid_data_d;
            r_skid_ctrl <= w_skid_ctrl_d;
`endif
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg (default and ELASTIC_PIPE_SKID_EN builds).
// A negedge monitor keeps a scoreboard of accepted entries and checks the order,
// the occupancy and the bubble rule. Scenario tasks add directed checks.
module tb_elastic_pipe_reg;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic [7:0]  ctrl_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [7:0]  ctrl_o;
    logic [1:0]  count_o;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en   = 1'b0;
    logic [39:0] sb[$];

    always #5 clk_i = ~clk_i;

    elastic_pipe_reg #(
        .DATA_W(32),
        .CTRL_W(8)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .ctrl_i (ctrl_i),
        .flush_i(flush_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .ctrl_o (ctrl_o),
        .count_o(count_o)
    );

    // Scoreboard monitor: inputs are stable mid-cycle, transfers happen at the next posedge.
    always @(negedge clk_i) begin
        logic [39:0] exp;
        if (mon_en) begin
            n_checks++;
            if ($isunknown(count_o) || int'(count_o) != sb.size()) begin
                n_errors++;
                $display("FAIL occupancy: count_o=%0d expected=%0d", count_o, sb.size());
            end
`ifndef ELASTIC_PIPE_SKID_EN
            n_checks++;
            if (count_o > 2'd1) begin
                n_errors++;
                $display("FAIL count_max: count_o=%0d expected<=1", count_o);
            end
`endif
            if (!valid_o) begin
                n_checks++;
                if (ctrl_o !== 8'h00) begin
                    n_errors++;
                    $display("FAIL bubble_ctrl: ctrl_o=%h expected=00", ctrl_o);
                end
            end
            if (!rst_i || flush_i) begin
                sb.delete();
            end else begin
                if (valid_o && ready_i) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected: got %h_%h expected no output", data_o, ctrl_o);
                    end else begin
                        exp = sb.pop_front();
                        if ({data_o, ctrl_o} !== exp) begin
                            n_errors++;
                            $display("FAIL sb_order: got %h_%h expected %h_%h",
                                     data_o, ctrl_o, exp[39:8], exp[7:0]);
                        end
                    end
                end
                if (valid_i && ready_o) sb.push_back({data_i, ctrl_i});
            end
        end
    end

    // Wait for the next edge, then step clear of it before driving or sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        ready_i = 1'b1;
        flush_i = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        ctrl_i  = 8'hFF;
        flush_i = 1'b1;
        ready_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({valid_o, ready_o, count_o, data_o, ctrl_o} !== {1'b0, 1'b1, 2'd0, 32'h0, 8'h0}) begin
            n_errors++;
            $display("FAIL reset: v=%b r=%b c=%0d d=%h ct=%h expected v=0 r=1 c=0 d=0 ct=0",
                     valid_o, ready_o, count_o, data_o, ctrl_o);
        end
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        mon_en  = 1'b1;
        tick();
    endtask

    task automatic test_single();
        valid_i = 1'b1;
        data_i  = 32'h11;
        ctrl_i  = 8'h81;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n_checks++;
        if ({valid_o, data_o, ctrl_o, count_o} !== {1'b1, 32'h11, 8'h81, 2'd1}) begin
            n_errors++;
            $display("FAIL single: v=%b d=%h ct=%h c=%0d expected v=1 d=11 ct=81 c=1",
                     valid_o, data_o, ctrl_o, count_o);
        end
        tick();
        n_checks++;
        if ({valid_o, data_o, ctrl_o} !== {1'b0, 32'h11, 8'h00}) begin
            n_errors++;
            $display("FAIL empty_hold: v=%b d=%h ct=%h expected v=0 d=11 ct=00",
                     valid_o, data_o, ctrl_o);
        end
    endtask

    task automatic test_stream();
        valid_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_i = i;
            ctrl_i = 8'(8'h10 + i);
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== 32'(i)) begin
                n_errors++;
                $display("FAIL stream[%0d]: v=%b d=%h expected v=1 d=%h", i, valid_o, data_o, i);
            end
        end
        idle(2);
    endtask

    task automatic test_stall();
        valid_i = 1'b1;
        data_i  = 32'hA;
        ctrl_i  = 8'h0A;
        ready_i = 1'b0;
        tick();
        data_i  = 32'hB;
        ctrl_i  = 8'h0B;
`ifdef ELASTIC_PIPE_SKID_EN
        tick();
        valid_i = 1'b0;
        n_checks++;
        if ({count_o, ready_o, data_o} !== {2'd2, 1'b0, 32'hA}) begin
            n_errors++;
            $display("FAIL skid_fill: c=%0d r=%b d=%h expected c=2 r=0 d=a",
                     count_o, ready_o, data_o);
        end
        ready_i = 1'b1;
        tick();
        n_checks++;
        if ({valid_o, data_o, count_o} !== {1'b1, 32'hB, 2'd1}) begin
            n_errors++;
            $display("FAIL skid_drain: v=%b d=%h c=%0d expected v=1 d=b c=1",
                     valid_o, data_o, count_o);
        end
`else
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_ready: ready_o=%b expected 0", ready_o);
        end
        tick();
        n_checks++;
        if ({data_o, count_o} !== {32'hA, 2'd1}) begin
            n_errors++;
            $display("FAIL stall_hold: d=%h c=%0d expected d=a c=1", data_o, count_o);
        end
        ready_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: ready_o=%b expected 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        n_checks++;
        if ({valid_o, data_o, count_o} !== {1'b1, 32'hB, 2'd1}) begin
            n_errors++;
            $display("FAIL replace: v=%b d=%h c=%0d expected v=1 d=b c=1",
                     valid_o, data_o, count_o);
        end
`endif
        idle(2);
    endtask

    task automatic test_flush();
        valid_i = 1'b1;
        data_i  = 32'h21;
        ctrl_i  = 8'h21;
        ready_i = 1'b0;
        tick();
`ifdef ELASTIC_PIPE_SKID_EN
        data_i = 32'h22;
        ctrl_i = 8'h22;
        tick();
`endif
        flush_i = 1'b1;
        ready_i = 1'b1;
        data_i  = 32'hEE;
        ctrl_i  = 8'hEE;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        n_checks++;
        if ({valid_o, ctrl_o, count_o, ready_o, data_o} !== {1'b0, 8'h0, 2'd0, 1'b1, 32'h21}) begin
            n_errors++;
            $display("FAIL flush: v=%b ct=%h c=%0d r=%b d=%h expected v=0 ct=0 c=0 r=1 d=21",
                     valid_o, ctrl_o, count_o, ready_o, data_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL flush_leak: v=%b d=%h expected v=0", valid_o, data_o);
            end
        end
    endtask

    task automatic test_reset_midstall();
        valid_i = 1'b1;
        data_i  = 32'h33;
        ctrl_i  = 8'h44;
        ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        rst_i   = 1'b0;
        tick();
        rst_i = 1'b1;
        n_checks++;
        if ({valid_o, data_o, ctrl_o, count_o} !== {1'b0, 32'h0, 8'h0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_stall: v=%b d=%h ct=%h c=%0d expected v=0 d=0 ct=0 c=0",
                     valid_o, data_o, ctrl_o, count_o);
        end
        valid_i = 1'b1;
        data_i  = 32'h5;
        ctrl_i  = 8'h05;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n_checks++;
        if ({valid_o, data_o, ctrl_o} !== {1'b1, 32'h5, 8'h05}) begin
            n_errors++;
            $display("FAIL after_reset: v=%b d=%h ct=%h expected v=1 d=5 ct=05",
                     valid_o, data_o, ctrl_o);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int budget;
        for (int k = 0; k < 400; k++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            data_i  = $urandom;
            ctrl_i  = 8'($urandom);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        budget  = 0;
        while ((valid_o || sb.size() != 0) && budget < 20) begin
            tick();
            budget++;
        end
        n_checks++;
        if (valid_o !== 1'b0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: v=%b pending=%0d expected v=0 pending=0",
                     valid_o, sb.size());
        end
    endtask

    initial begin
        valid_i = 1'b0;
        ready_i = 1'b1;
        flush_i = 1'b0;
        data_i  = '0;
        ctrl_i  = '0;
        rst_i   = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_reset_midstall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
